// File: rtl/dm_port_arbiter_if.sv
// Bundle of the two requester channels and the data-memory port of dm_port_arbiter.
// slave = arbiter side, master = requesters plus memory.
interface dm_port_arbiter_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [3:0]  be0;
  logic [3:0]  be1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic        done0;
  logic        done1;
  logic        err0;
  logic        err1;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic        mem_en;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        owner;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, be0, be1, wdata0, wdata1, mem_rdata,
    output done0, done1, err0, err1, rdata0, rdata1,
    output mem_en, mem_be, mem_addr, mem_wdata, busy, owner
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, be0, be1, wdata0, wdata1, mem_rdata,
    input  done0, done1, err0, err1, rdata0, rdata1,
    input  mem_en, mem_be, mem_addr, mem_wdata, busy, owner
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Shares the single data-memory port between the CPU M stage (0) and the DMA master (1).
// One access in flight at a time; reads wait RD_LAT cycles for mem_rdata.
module dm_port_arbiter #(
  parameter int unsigned RD_LAT   = 2,
  parameter bit          CPU_PRIO = 1'b0
) (
  input logic              clk,
  input logic              reset,
  dm_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic        last_grant_r;
  logic        owner_r;
  logic        we_r;
  logic        err_r;
  logic [29:0] waddr_r;
  logic [3:0]  be_r;
  logic [31:0] wdata_r;
  logic [31:0] rdata0_r;
  logic [31:0] rdata1_r;
  logic [2:0]  cnt_r;
  logic        any_req_s;
  logic        win_s;

  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100, 4'b1000: be_legal = 1'b1;
      default:                             be_legal = 1'b0;
    endcase
  endfunction

  assign any_req_s = bus.req0 | bus.req1;

  // Winner of the IDLE sample; ties go to ~last_grant unless the CPU has fixed priority
  always_comb begin
    win_s = 1'b0;
    if (bus.req0 && bus.req1) begin
      win_s = CPU_PRIO ? 1'b0 : ~last_grant_r;
    end else if (bus.req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) state_s = ISSUE;
        else           state_s = IDLE;
      end
      ISSUE: begin
        if (we_r) state_s = DONE;
        else      state_s = WAIT;
      end
      WAIT: begin
        if (cnt_r == 3'd0) state_s = DONE;
        else               state_s = WAIT;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Transaction latch, read-latency counter, read capture and round-robin history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      we_r         <= 1'b0;
      err_r        <= 1'b0;
      waddr_r      <= 30'd0;
      be_r         <= 4'd0;
      wdata_r      <= 32'd0;
      rdata0_r     <= 32'd0;
      rdata1_r     <= 32'd0;
      cnt_r        <= 3'd0;
    end else begin
      if ((state_r == IDLE) && any_req_s) begin
        owner_r <= win_s;
        if (win_s) begin
          we_r    <= bus.we1;
          waddr_r <= bus.addr1[31:2];
          be_r    <= bus.be1;
          wdata_r <= bus.wdata1;
          err_r   <= bus.we1 & ~be_legal(bus.be1);
        end else begin
          we_r    <= bus.we0;
          waddr_r <= bus.addr0[31:2];
          be_r    <= bus.be0;
          wdata_r <= bus.wdata0;
          err_r   <= bus.we0 & ~be_legal(bus.be0);
        end
      end
      // Counter starts at RD_LAT-1 so WAIT spans exactly RD_LAT cycles
      if (state_r == ISSUE) begin
        cnt_r <= 3'(RD_LAT - 32'd1);
      end else if (state_r == WAIT) begin
        cnt_r <= cnt_r - 3'd1;
      end
      if ((state_r == WAIT) && (cnt_r == 3'd0)) begin
        if (owner_r) rdata1_r <= bus.mem_rdata;
        else         rdata0_r <= bus.mem_rdata;
      end
      if (state_r == DONE) begin
        last_grant_r <= owner_r;
      end
    end
  end

  // An illegal write keeps the strobe low; the error surfaces with done instead
  assign bus.mem_en    = (state_r == ISSUE) && !err_r;
  assign bus.mem_be    = ((state_r == ISSUE) && we_r && !err_r) ? be_r : 4'b0000;
  assign bus.mem_addr  = {waddr_r, 2'b00};
  assign bus.mem_wdata = wdata_r;
  assign bus.done0     = (state_r == DONE) && !owner_r;
  assign bus.done1     = (state_r == DONE) && owner_r;
  assign bus.err0      = (state_r == DONE) && !owner_r && err_r;
  assign bus.err1      = (state_r == DONE) && owner_r && err_r;
  assign bus.rdata0    = rdata0_r;
  assign bus.rdata1    = rdata1_r;
  assign bus.busy      = (state_r != IDLE);
  assign bus.owner     = owner_r;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed cases plus random traffic checked against a
// transaction-level model (grant rule, fixed per-access latency, byte-lane memory image).
module tb_dm_port_arbiter;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_port_arbiter_if bus ();
  dm_port_arbiter_if bus_fp ();

  dm_port_arbiter #(.RD_LAT(LAT), .CPU_PRIO(1'b0)) dut    (.clk(clk), .reset(reset), .bus(bus));
  dm_port_arbiter #(.RD_LAT(1),   .CPU_PRIO(1'b1)) dut_fp (.clk(clk), .reset(reset), .bus(bus_fp));

  function automatic logic [31:0] init_word(input int w);
    if (w == 8) init_word = 32'h1234_5678;
    else        init_word = {8'(w), 8'hA5, 8'(w * 7), 8'h3C};
  endfunction

  function automatic logic be_ok(input logic [3:0] be);
    be_ok = be inside {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  endfunction

  // Memory device behind the main arbiter: 16 aliased words, read data valid LAT cycles after issue
  logic [31:0] dev_mem [16];
  logic        pipe_v  [8];
  logic [3:0]  pipe_a  [8];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) dev_mem[i] <= init_word(i);
      for (int i = 0; i < 8; i++) pipe_v[i] <= 1'b0;
    end else begin
      if (bus.mem_en)
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) dev_mem[bus.mem_addr[5:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      pipe_v[0] <= bus.mem_en && (bus.mem_be == 4'b0000);
      pipe_a[0] <= bus.mem_addr[5:2];
      for (int i = 1; i < 8; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
    end
  end
  assign bus.mem_rdata = pipe_v[LAT-1] ? dev_mem[pipe_a[LAT-1]] : 32'hBAD0_BAD0;

  // Memory for the fixed-priority instance: returns ~address one cycle after issue
  logic [31:0] fp_rd;
  always @(posedge clk) fp_rd <= ~bus_fp.mem_addr;
  assign bus_fp.mem_rdata = fp_rd;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model state
  bit          act;
  int          g, L, free_at;
  bit          last_g, e_owner, m_own, m_we, m_legal;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic [31:0] ref_mem [16];
  logic [31:0] exp_rd0, exp_rd1;
  bit          m_done0, m_done1, m_gnt;

  logic [3:0] legal_tab [7] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_req(input int k, input logic on);
    logic w;
    logic [31:0] a, d;
    logic [3:0] b;
    w = 1'($urandom_range(0, 1));
    a = {26'd0, 6'($urandom_range(0, 63))};
    d = $urandom;
    if ($urandom_range(0, 9) < 7) b = legal_tab[$urandom_range(0, 6)];
    else                          b = 4'($urandom_range(0, 15));
    if (k == 0) begin
      bus.req0 = on; bus.we0 = w; bus.addr0 = a; bus.be0 = b; bus.wdata0 = d;
    end else begin
      bus.req1 = on; bus.we1 = w; bus.addr1 = a; bus.be1 = b; bus.wdata1 = d;
    end
  endtask

  // One clock: predict what the edge does from the pre-edge inputs, then compare every output
  task automatic step();
    logic rs, r0, r1, w0, w1, emen, ed0, ed1;
    logic [31:0] a0, a1, d0, d1;
    logic [3:0] b0, b1, embe;
    rs = reset; r0 = bus.req0; r1 = bus.req1; w0 = bus.we0; w1 = bus.we1;
    a0 = bus.addr0; a1 = bus.addr1; d0 = bus.wdata0; d1 = bus.wdata1; b0 = bus.be0; b1 = bus.be1;
    @(posedge clk);
    #1;
    cyc++;
    m_done0 = 1'b0; m_done1 = 1'b0; m_gnt = 1'b0;
    if (act && cyc > g + L) act = 1'b0;
    if (rs && !act && cyc >= free_at && (r0 || r1)) begin
      m_own   = (r0 && r1) ? !last_g : r1;
      m_we    = m_own ? w1 : w0;
      m_addr  = m_own ? a1 : a0;
      m_be    = m_own ? b1 : b0;
      m_wdata = m_own ? d1 : d0;
      m_legal = !m_we || be_ok(m_be);
      L = m_we ? 1 : 1 + LAT;
      g = cyc; free_at = cyc + L + 2; act = 1'b1; m_gnt = 1'b1; e_owner = m_own;
      if (m_we && m_legal)
        for (int b = 0; b < 4; b++)
          if (m_be[b]) ref_mem[m_addr[5:2]][8*b +: 8] = m_wdata[8*b +: 8];
    end
    emen = act && (cyc == g) && m_legal;
    embe = (emen && m_we) ? m_be : 4'b0000;
    if (act && cyc == g + L) begin
      if (m_own) m_done1 = 1'b1; else m_done0 = 1'b1;
      if (!m_we) begin
        if (m_own) exp_rd1 = ref_mem[m_addr[5:2]];
        else       exp_rd0 = ref_mem[m_addr[5:2]];
      end
      last_g = m_own;
    end
    ed0 = m_done0; ed1 = m_done1;
    chk("busy", bus.busy, act);
    chk("owner", bus.owner, e_owner);
    chk("mem_en", bus.mem_en, emen);
    chk("mem_be", bus.mem_be, embe);
    if (act && cyc == g) begin
      chk("mem_addr", bus.mem_addr, {m_addr[31:2], 2'b00});
      chk("mem_wdata", bus.mem_wdata, m_wdata);
    end
    chk("done0", bus.done0, ed0);
    chk("done1", bus.done1, ed1);
    chk("err0", bus.err0, ed0 && m_we && !m_legal);
    chk("err1", bus.err1, ed1 && m_we && !m_legal);
    chk("rdata0", bus.rdata0, exp_rd0);
    chk("rdata1", bus.rdata1, exp_rd1);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    act = 1'b0; last_g = 1'b1; e_owner = 1'b0; exp_rd0 = 32'd0; exp_rd1 = 32'd0; free_at = 0;
    m_done0 = 1'b0; m_done1 = 1'b0; m_gnt = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    chk("rst_mem_en", bus.mem_en, 1'b0);
    chk("rst_mem_be", bus.mem_be, 4'b0000);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_owner", bus.owner, 1'b0);
    chk("rst_done", {bus.done1, bus.done0}, 2'b00);
    chk("rst_rdata0", bus.rdata0, 32'd0);
    chk("rst_rdata1", bus.rdata1, 32'd0);
  endtask

  bit  pend [2];
  int  seq [4];
  int  nseq, fp_d0, fp_d1;
  bit  seen, on, dk, rk;

  initial begin
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    bus_fp.req0 = 1'b0; bus_fp.we0 = 1'b0; bus_fp.addr0 = 32'd0; bus_fp.be0 = 4'd0; bus_fp.wdata0 = 32'd0;
    bus_fp.req1 = 1'b0; bus_fp.we1 = 1'b0; bus_fp.addr1 = 32'd0; bus_fp.be1 = 4'd0; bus_fp.wdata1 = 32'd0;
    reset = 1'b1;
    #2;
    apply_reset();
    chk("rst_fp_busy", bus_fp.busy, 1'b0);
    repeat (3) step();
    reset = 1'b1;
    step();

    // Single CPU write, unaligned byte address
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h0000_1006; bus.be0 = 4'b1100; bus.wdata0 = 32'hABCD_0000;
    step();
    chk("w_mem_en", bus.mem_en, 1'b1);
    chk("w_mem_addr", bus.mem_addr, 32'h0000_1004);
    chk("w_mem_be", bus.mem_be, 4'b1100);
    chk("w_mem_wdata", bus.mem_wdata, 32'hABCD_0000);
    step();
    chk("w_done0", bus.done0, 1'b1);
    chk("w_err0", bus.err0, 1'b0);
    bus.req0 = 1'b0;
    repeat (2) step();

    // DMA read, RD_LAT=2
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h0000_0020; bus.be1 = 4'b0000;
    step();
    chk("r_mem_en", bus.mem_en, 1'b1);
    chk("r_mem_be", bus.mem_be, 4'b0000);
    chk("r_mem_addr", bus.mem_addr, 32'h0000_0020);
    repeat (2) step();
    chk("r_early_done1", bus.done1, 1'b0);
    step();
    chk("r_done1", bus.done1, 1'b1);
    chk("r_rdata1", bus.rdata1, 32'h1234_5678);
    bus.req1 = 1'b0;
    repeat (2) step();

    // Round-robin tie with both requests held
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h0000_0010; bus.be0 = 4'b0011; bus.wdata0 = 32'h0000_1111;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h0000_0014; bus.be1 = 4'b1000; bus.wdata1 = 32'h2200_0000;
    nseq = 0;
    for (int i = 0; i < 4; i++) seq[i] = 9;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("rr_excl", bus.done0 & bus.done1, 1'b0);
      if (nseq < 4 && bus.done0) begin seq[nseq] = 0; nseq++; end
      else if (nseq < 4 && bus.done1) begin seq[nseq] = 1; nseq++; end
    end
    chk("rr_count", nseq, 4);
    for (int i = 0; i < 4; i++) chk("rr_order", seq[i], i % 2);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (2) step();

    // Illegal write byte enable
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h0000_0008; bus.be0 = 4'b0101; bus.wdata0 = 32'h5555_5555;
    step();
    chk("ill_mem_en_issue", bus.mem_en, 1'b0);
    step();
    chk("ill_mem_en_done", bus.mem_en, 1'b0);
    chk("ill_done0", bus.done0, 1'b1);
    chk("ill_err0", bus.err0, 1'b1);
    bus.req0 = 1'b0;
    repeat (2) step();

    // Fixed priority instance: CPU wins every tie while it keeps requesting
    bus_fp.req0 = 1'b1; bus_fp.we0 = 1'b1; bus_fp.addr0 = 32'h0000_0010; bus_fp.be0 = 4'b1111; bus_fp.wdata0 = 32'h0F0F_0F0F;
    bus_fp.req1 = 1'b1; bus_fp.we1 = 1'b0; bus_fp.addr1 = 32'h0000_0040; bus_fp.be1 = 4'b0000;
    fp_d0 = 0; fp_d1 = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      fp_d0 += int'(bus_fp.done0);
      fp_d1 += int'(bus_fp.done1);
      chk("fp_excl", bus_fp.done0 & bus_fp.done1, 1'b0);
    end
    chk("fp_cpu_grants", fp_d0, 4);
    chk("fp_dma_held", fp_d1, 0);
    bus_fp.req0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      if (bus_fp.done1) begin
        seen = 1'b1;
        chk("fp_rdata1", bus_fp.rdata1, 32'hFFFF_FFBF);
      end
    end
    chk("fp_dma_served", seen, 1'b1);
    bus_fp.req1 = 1'b0;
    repeat (2) step();

    // Reset in the middle of a DMA read
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h0000_0024; bus.be1 = 4'b0000;
    repeat (2) step();
    chk("mid_busy", bus.busy, 1'b1);
    apply_reset();
    bus.req1 = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h0000_0020; bus.be0 = 4'b0000;
    repeat (4) step();
    chk("post_rst_done0", bus.done0, 1'b1);
    chk("post_rst_rdata0", bus.rdata0, 32'h1234_5678);
    bus.req0 = 1'b0;
    repeat (2) step();

    // Random traffic against the model
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int n = 0; n < 500; n++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        dk = (k == 0) ? m_done0 : m_done1;
        rk = (k == 0) ? bus.req0 : bus.req1;
        if (dk) begin
          on = ($urandom_range(0, 1) == 0);
          set_req(k, on);
          pend[k] = on;
        end else if (!pend[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            set_req(k, 1'b1);
            pend[k] = 1'b1;
          end
        end else if (m_gnt && (int'(m_own) == k) && rk && ($urandom_range(0, 3) == 0)) begin
          set_req(k, 1'b0);
        end
      end
    end
    for (int n = 0; n < 30; n++) begin
      step();
      if (m_done0) set_req(0, 1'b0);
      if (m_done1) set_req(1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: requester 0 is the CPU M stage, requester 1 is the external/DMA master.
- Each requester presents a word address, a 4-bit byte enable and write data. The byte enable and write data come already lane-aligned from the store byte-enable logic.
- The block arbitrates between the requesters, sequences one memory access at a time with a configurable read latency, and returns a one-cycle done pulse plus read data.

Parameters:
- RD_LAT, 2, cycles from the mem_en issue cycle until mem_rdata is valid; legal range 1..7.
- CPU_PRIO, 0, 0 = round-robin on simultaneous requests; 1 = requester 0 always wins ties.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request; held high with fields stable until the matching done
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  32  byte address; bits [1:0] are ignored for the memory address
- be0 / be1  in  4  byte enables, lane-aligned
- wdata0 / wdata1  in  32  lane-aligned write data
- done0 / done1  out  1  one-cycle completion pulse
- err0 / err1  out  1  pulses together with done when the write byte enable is illegal
- rdata0 / rdata1  out  32  read data, registered; holds until that requester's next read completes
- mem_en  out  1  memory access strobe
- mem_be  out  4  memory write strobes; 0000 for reads
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_wdata  out  32  write data to memory
- mem_rdata  in  32  memory read data
- busy  out  1  high whenever state is not IDLE
- owner  out  1  index of the latched winner

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie).
  - All outputs are 0, including rdata0, rdata1 and owner.
  - Asserting reset mid-transaction aborts it immediately: mem_en drops in the same cycle and no done is issued.
- FSM states are IDLE, ISSUE, WAIT and DONE; all outputs are registered or decoded from registered state.
- IDLE:
  - If exactly one req is high, that requester wins.
  - If both are high, the winner is ~last_grant, or 0 when CPU_PRIO=1.
  - The winner's we, addr, be and wdata are latched into owner and the transaction registers; next state is ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE (exactly one cycle):
  - mem_en=1, mem_addr={addr[31:2],2'b00}, mem_wdata=latched wdata, mem_be = we ? be : 4'b0000.
  - Write: next state is DONE.
  - Read: load counter with RD_LAT-1 and go to WAIT.
- Legal write byte enables are 1111, 0011, 1100, 0001, 0010, 0100 and 1000.
  - Any other value, including 0000, gives mem_en=0 and mem_be=0 in ISSUE; the transaction goes to DONE with err_k=1.
  - For reads the latched be is ignored.
- WAIT:
  - The counter decrements each cycle.
  - When the counter is 0, capture mem_rdata into rdata_owner and go to DONE.
  - With RD_LAT=1, WAIT lasts one cycle and the capture happens in that cycle.
- DONE (one cycle):
  - done_owner=1 (with err_owner when flagged); last_grant<=owner; next state is IDLE.
  - The requester must not re-sample done; req may remain high for a new back-to-back request, which is sampled in IDLE on the following cycle.
- Latency from the req-sampled edge to the done pulse: write = 2 cycles (ISSUE, DONE); read = 2 + RD_LAT cycles.
- A req dropping after it has been latched does not cancel the transaction; done still pulses.
- The losing requester holds its req and is served next (starvation-free under round-robin).
- Only one of done0/done1 is ever high in a cycle.
- mem_en is never high outside ISSUE.

Test Plan:
- Single CPU write: req0=1, we0=1, addr0=0x0000_1006, be0=1100, wdata0=0xABCD_0000 → ISSUE cycle shows mem_addr=0x0000_1004, mem_be=1100, mem_wdata=0xABCD_0000; done0 pulses 2 cycles after the request edge; err0=0.
- Read latency (RD_LAT=2): memory model returns 0x1234_5678 two cycles after mem_en; req1 read at 0x20 → done1 pulses 4 cycles after the request edge, rdata1=0x1234_5678, mem_be=0000.
- Round-robin tie, CPU_PRIO=0: req0 and req1 both held high continuously → grants alternate 0,1,0,1; done0 and done1 are never high together.
- Fixed priority, CPU_PRIO=1: req0 and req1 both held high → requester 0 is granted every time while req0 stays high; requester 1 is served only after req0 drops.
- Illegal byte enable: req0 write with be0=0101 → mem_en stays 0 throughout; done0 and err0 pulse together.
- Reset during WAIT: drive reset=0 mid-read → mem_en=0, busy=0, owner=0, rdata0 and rdata1 are 0 immediately, no done pulse; after release, a new request completes normally.
